// File: rtl/pc_redirect_ctrl_if.sv
// Branch-resolution / fetch-PC interface between the execute-side redirect source
// and the fetch PC controller.
interface pc_redirect_ctrl_if #(
  parameter int unsigned PC_W = 9
);
  logic            stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic [PC_W-1:0] PC;
  logic            Flush_IF_ID;
  logic            Flush_ID_EX;
  logic            Redirect_Pending;
  logic            Misaligned;
  logic [15:0]     RedirCount;

  // Redirect source / observer side.
  modport master (
    output stall, PcSel, BrPC,
    input  PC, Flush_IF_ID, Flush_ID_EX, Redirect_Pending, Misaligned, RedirCount
  );

  // Fetch PC controller side.
  modport slave (
    input  stall, PcSel, BrPC,
    output PC, Flush_IF_ID, Flush_ID_EX, Redirect_Pending, Misaligned, RedirCount
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register and redirect controller. Applies branch redirects, squashes the
// IF/ID and ID/EX registers when a redirect takes effect, and defers a redirect that
// arrives while the front end is stalled until the stall releases.
module pc_redirect_ctrl #(
  parameter int unsigned PC_W = 9
) (
  input logic              clk,
  input logic              reset,
  pc_redirect_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StRun, StPending} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_mis_q, pend_mis_d;
  logic            mis_q, mis_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [PC_W-1:0] tgt;
  logic            tgt_mis;
  logic [15:0]     cnt_sat_inc;
  logic            flush;
  logic            unused_brpc;

  // Target keeps word alignment; low two bits only feed the sticky misalign flag.
  assign tgt         = {bus.BrPC[PC_W-1:2], 2'b00};
  assign tgt_mis     = |bus.BrPC[1:0];
  assign cnt_sat_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign unused_brpc = ^bus.BrPC[31:PC_W];

  // Next-state and flush decode for the RUN/PENDING controller.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_mis_d = pend_mis_q;
    mis_d      = mis_q;
    cnt_d      = cnt_q;
    flush      = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.PcSel && !bus.stall) begin
          flush = 1'b1;
          pc_d  = tgt;
          cnt_d = cnt_sat_inc;
          mis_d = mis_q | tgt_mis;
        end else if (bus.PcSel && bus.stall) begin
          // Frozen pipeline: hold the request, no squash until it can take effect.
          pend_tgt_d = tgt;
          pend_mis_d = tgt_mis;
          state_d    = StPending;
        end else if (!bus.stall) begin
          pc_d = pc_q + PC_W'(4);
        end
      end
      StPending: begin
        // New requests here come from younger wrong-path instructions and are dropped.
        if (!bus.stall) begin
          flush   = 1'b1;
          pc_d    = pend_tgt_q;
          cnt_d   = cnt_sat_inc;
          mis_d   = mis_q | pend_mis_q;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      pc_q       <= '0;
      pend_tgt_q <= '0;
      pend_mis_q <= 1'b0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_mis_q <= pend_mis_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs; flushes are suppressed while reset is asserted.
  assign bus.PC               = pc_q;
  assign bus.Flush_IF_ID      = flush & ~reset;
  assign bus.Flush_ID_EX      = flush & ~reset;
  assign bus.Redirect_Pending = (state_q == StPending);
  assign bus.Misaligned       = mis_q;
  assign bus.RedirCount       = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: a cycle model pushes expected results into
// a queue as each cycle's stimulus is driven; each test pops and compares after the edge.
module tb_pc_redirect_ctrl;

  localparam int unsigned PC_W = 9;
  localparam int unsigned ObsW = PC_W + 20;

  typedef struct packed {
    logic            flush;
    logic [PC_W-1:0] pc;
    logic            pend;
    logic            mis;
    logic [15:0]     cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  pc_redirect_ctrl_if #(.PC_W(PC_W)) bus_if ();

  pc_redirect_ctrl #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic flush_if_seen, flush_ex_seen;

  // Reference model state.
  logic [PC_W-1:0] m_pc   = '0;
  logic [PC_W-1:0] m_tgt  = '0;
  logic            m_pend = 1'b0;
  logic            m_tbit = 1'b0;
  logic            m_mis  = 1'b0;
  logic [15:0]     m_cnt  = '0;

  function automatic logic [ObsW-1:0] obs();
    return {flush_if_seen, flush_ex_seen, bus_if.PC, bus_if.Redirect_Pending,
            bus_if.Misaligned, bus_if.RedirCount};
  endfunction

  function automatic logic [ObsW-1:0] exp_vec(input exp_t e);
    return {e.flush, e.flush, e.pc, e.pend, e.mis, e.cnt};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Drive one cycle at the falling edge, sample flushes before the rising edge,
  // advance the model and queue its prediction, then return 1 time unit after the edge.
  task automatic step(input logic r, input logic s, input logic p, input logic [31:0] b);
    exp_t            e;
    logic [PC_W-1:0] t;
    @(negedge clk);
    reset         = r;
    bus_if.stall  = s;
    bus_if.PcSel  = p;
    bus_if.BrPC   = b;
    #1;
    flush_if_seen = bus_if.Flush_IF_ID;
    flush_ex_seen = bus_if.Flush_ID_EX;
    t      = {b[PC_W-1:2], 2'b00};
    e.flush = 1'b0;
    e.pc    = m_pc;
    e.pend  = m_pend;
    e.mis   = m_mis;
    e.cnt   = m_cnt;
    if (r) begin
      e      = '0;
      m_tgt  = '0;
      m_tbit = 1'b0;
    end else if (m_pend) begin
      if (!s) begin
        e.flush = 1'b1;
        e.pc    = m_tgt;
        e.cnt   = sat_inc(m_cnt);
        e.mis   = m_mis | m_tbit;
        e.pend  = 1'b0;
      end
    end else if (p && !s) begin
      e.flush = 1'b1;
      e.pc    = t;
      e.cnt   = sat_inc(m_cnt);
      e.mis   = m_mis | (b[1:0] != 2'b00);
    end else if (p && s) begin
      e.pend = 1'b1;
      m_tgt  = t;
      m_tbit = (b[1:0] != 2'b00);
    end else if (!s) begin
      e.pc = m_pc + PC_W'(4);
    end
    m_pc   = e.pc;
    m_pend = e.pend;
    m_mis  = e.mis;
    m_cnt  = e.cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 1'b0, 1'b0, 32'h0);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        $display("FAIL reset_model cyc%0d: got %h exp %h", i, obs(), exp_vec(e));
      end
      checks++;
      if (bus_if.PC !== PC_W'(4 * i) || bus_if.RedirCount !== 16'd0 ||
          bus_if.Misaligned !== 1'b0 || bus_if.Redirect_Pending !== 1'b0) begin
        errors++;
        $display("FAIL reset_seq cyc%0d: got pc=%h cnt=%h mis=%b pend=%b exp pc=%h, flags 0",
                 i, bus_if.PC, bus_if.RedirCount, bus_if.Misaligned,
                 bus_if.Redirect_Pending, PC_W'(4 * i));
      end
    end
  endtask

  task automatic test_wrap();
    exp_t            e;
    logic [PC_W-1:0] want [3];
    want = '{9'h1F8, 9'h1FC, 9'h000};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, i == 0, 32'h0000_01F8);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== exp_vec(e) || bus_if.PC !== want[i]) begin
        errors++;
        $display("FAIL wrap cyc%0d: got %h pc=%h exp %h pc=%h", i, obs(), bus_if.PC,
                 exp_vec(e), want[i]);
      end
    end
  endtask

  task automatic test_direct();
    exp_t            e;
    logic            p_tab  [7];
    logic [PC_W-1:0] pc_tab [7];
    logic            fl_tab [7];
    p_tab  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pc_tab = '{9'h000, 9'h004, 9'h008, 9'h00C, 9'h010, 9'h040, 9'h044};
    fl_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      step(i == 0, 1'b0, p_tab[i], 32'h0000_0040);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== exp_vec(e) || bus_if.PC !== pc_tab[i] ||
          flush_if_seen !== fl_tab[i] || flush_ex_seen !== fl_tab[i] ||
          bus_if.RedirCount !== ((i >= 5) ? 16'd1 : 16'd0)) begin
        errors++;
        $display("FAIL direct cyc%0d: got %h exp %h (pc want %h flush want %b)", i, obs(),
                 exp_vec(e), pc_tab[i], fl_tab[i]);
      end
    end
  endtask

  task automatic test_deferred();
    exp_t        e;
    logic        s_tab [8];
    logic        p_tab [8];
    logic [31:0] b_tab [8];
    s_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    p_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    b_tab = '{32'h0, 32'h0, 32'h80, 32'h100, 32'h100, 32'h100, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      step(i == 0, s_tab[i], p_tab[i], b_tab[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        $display("FAIL deferred_model cyc%0d: got %h exp %h", i, obs(), exp_vec(e));
      end
      if (i >= 2 && i <= 5) begin
        checks++;
        if (bus_if.Redirect_Pending !== 1'b1 || flush_if_seen !== 1'b0 ||
            flush_ex_seen !== 1'b0 || bus_if.PC !== 9'h004) begin
          errors++;
          $display("FAIL deferred_hold cyc%0d: got pend=%b fl=%b%b pc=%h exp 1 00 004", i,
                   bus_if.Redirect_Pending, flush_if_seen, flush_ex_seen, bus_if.PC);
        end
      end
      if (i == 6) begin
        checks++;
        if (flush_if_seen !== 1'b1 || flush_ex_seen !== 1'b1 || bus_if.PC !== 9'h080 ||
            bus_if.RedirCount !== 16'd1 || bus_if.Redirect_Pending !== 1'b0) begin
          errors++;
          $display("FAIL deferred_apply: got fl=%b%b pc=%h cnt=%h pend=%b exp 11 080 1 0",
                   flush_if_seen, flush_ex_seen, bus_if.PC, bus_if.RedirCount,
                   bus_if.Redirect_Pending);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i == 3, i == 0, 32'h0000_0046);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== exp_vec(e) || bus_if.Misaligned !== 1'b1) begin
        errors++;
        $display("FAIL misaligned cyc%0d: got %h mis=%b exp %h mis=1", i, obs(),
                 bus_if.Misaligned, exp_vec(e));
      end
      if (i == 0) begin
        checks++;
        if (bus_if.PC !== 9'h044) begin
          errors++;
          $display("FAIL misaligned_pc: got %h exp 044", bus_if.PC);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] b;
    for (int i = 0; i < 6; i++) begin
      b = $urandom;
      step(1'b0, 1'b0, 1'b1, b);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== exp_vec(e) || flush_if_seen !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %h exp %h", i, obs(), exp_vec(e));
      end
    end
  endtask

  task automatic test_saturation_reset();
    exp_t e;
    int   n = 0;
    while (m_cnt != 16'hFFFF) begin
      step(1'b0, 1'b0, 1'b1, $urandom);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        if (errors < 20) $display("FAIL sat_climb n%0d: got %h exp %h", n, obs(), exp_vec(e));
      end
      n++;
    end
    step(1'b0, 1'b0, 1'b1, 32'h0000_0020);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== exp_vec(e) || bus_if.RedirCount !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h cnt=%h exp %h cnt=ffff", obs(), bus_if.RedirCount,
               exp_vec(e));
    end
    step(1'b0, 1'b1, 1'b1, 32'h0000_0080);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== exp_vec(e) || bus_if.Redirect_Pending !== 1'b1) begin
      errors++;
      $display("FAIL sat_enter_pend: got %h exp %h", obs(), exp_vec(e));
    end
    // Reset with stall low: the pending redirect would otherwise apply this cycle.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== exp_vec(e) || bus_if.PC !== 9'h000 || bus_if.RedirCount !== 16'd0 ||
        bus_if.Redirect_Pending !== 1'b0 || flush_if_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_pend: got %h exp %h", obs(), exp_vec(e));
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== exp_vec(e) || bus_if.PC !== 9'h004 || bus_if.Misaligned !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got %h pc=%h exp %h pc=004", obs(), bus_if.PC, exp_vec(e));
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus_if.stall = 1'b0;
    bus_if.PcSel = 1'b0;
    bus_if.BrPC  = '0;
    test_reset();
    test_wrap();
    test_direct();
    test_deferred();
    test_misaligned();
    test_back_to_back();
    test_saturation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
